// File: rtl/delay_line_reader_pkg.sv
// delay_line_reader_pkg
//   Shared sizing helpers for the delay-line reader and its users (the
//   complex-multiplier top sizes its operand alignment from the same values).
//   dl_depth(deep_bit)     : number of RAM entries, 2**deep_bit
//   dl_max_delay(deep_bit) : largest programmable delay, 2**deep_bit-1
package delay_line_reader_pkg;

  localparam int unsigned DL_DEEP_BIT_DEF = 4;

  function automatic int unsigned dl_depth(input int unsigned deep_bit);
    return 32'(1) << deep_bit;
  endfunction

  function automatic int unsigned dl_max_delay(input int unsigned deep_bit);
    return (32'(1) << deep_bit) - 1;
  endfunction

  localparam int unsigned DL_DEPTH     = dl_depth(DL_DEEP_BIT_DEF);
  localparam int unsigned DL_MAX_DELAY = dl_max_delay(DL_DEEP_BIT_DEF);

endpackage

// File: rtl/delay_line_reader_sdp_ram.sv
// sdp_ram
//   Simple dual-port RAM: one synchronous write port, one asynchronous read
//   port. No reset, so it maps onto distributed RAM.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : combinational read data
module sdp_ram
  import delay_line_reader_pkg::*;
#(
  parameter int DEEP_BIT   = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEEP_BIT-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DEEP_BIT-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = dl_depth(DEEP_BIT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/delay_line_reader.sv
// delay_line_reader
//   Circular-RAM delay line: on each enabled cycle returns the sample
//   accepted i_shift_taps enables earlier, with fill tracking so the valid
//   pulse only marks genuinely delayed samples.
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_shift_en   : sample strobe
//   i_shift_taps : delay in enabled samples, 0..2**DEEP_BIT-1
//   i_data_in    : sample accepted when i_shift_en=1
//   o_data_out   : delayed sample (registered)
//   o_data_valid : one-cycle pulse, o_data_out is genuine
//   Optional: define DELAY_LINE_TAP_FLUSH_EN to restart fill tracking
//   whenever the tap setting changes.
module delay_line_reader
  import delay_line_reader_pkg::*;
#(
  parameter int DEEP_BIT   = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_shift_en,
  input  logic [DEEP_BIT-1:0]   i_shift_taps,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid
);

  localparam logic [DEEP_BIT-1:0] FILL_MAX = DEEP_BIT'(dl_max_delay(DEEP_BIT));

  logic [DEEP_BIT-1:0]   wr_ptr;
  logic [DEEP_BIT-1:0]   rd_addr;
  logic [DEEP_BIT-1:0]   fill_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  tap_chg;
  logic                  vld_now;

  // Natural DEEP_BIT-bit wrap; for taps>0 this never equals wr_ptr, so the
  // async read never sees the word being written this edge.
  assign rd_addr = wr_ptr - i_shift_taps;

`ifdef DELAY_LINE_TAP_FLUSH_EN
  logic [DEEP_BIT-1:0] taps_q;
  assign tap_chg = (i_shift_taps != taps_q);

  always_ff @(posedge i_clk) begin
    if (i_rst)           taps_q <= '0;
    else if (i_shift_en) taps_q <= i_shift_taps;
  end
`else
  assign tap_chg = 1'b0;
`endif

  // Validity uses the fill count before this cycle's sample is counted.
  assign vld_now = i_shift_en && !tap_chg && (fill_cnt >= i_shift_taps);

  sdp_ram #(
    .DEEP_BIT   (DEEP_BIT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (i_shift_en && !i_rst),
    .i_waddr (wr_ptr),
    .i_wdata (i_data_in),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= vld_now;
      if (i_shift_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        // Zero delay bypasses the RAM: the sample is not in memory yet.
        o_data_out <= (i_shift_taps == '0) ? i_data_in : rd_data;
        if (tap_chg)                    fill_cnt <= DEEP_BIT'(1);
        else if (fill_cnt != FILL_MAX)  fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_reader.sv
module tb_delay_line_reader;

  localparam int DB  = 4;
  localparam int DW  = 16;
  localparam int MAXD = 15;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_shift_en;
  logic [DB-1:0] i_shift_taps;
  logic [DW-1:0] i_data_in;
  logic [DW-1:0] o_data_out;
  logic          o_data_valid;

  int n_chk  = 0;
  int n_fail = 0;

  delay_line_reader #(.DEEP_BIT(DB), .DATA_WIDTH(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_shift_en   (i_shift_en),
    .i_shift_taps (i_shift_taps),
    .i_data_in    (i_data_in),
    .o_data_out   (o_data_out),
    .o_data_valid (o_data_valid)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: history of samples since reset, fill count as an int.
  logic [DW-1:0] hist[$];
  int            m_fill  = 0;
  int            m_tapsq = 0;
  logic [DW-1:0] m_out   = '0;
  bit            m_vld   = 1'b0;
  bit            m_known = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int taps, input logic [DW-1:0] data);
    bit chg;
    if (rst) begin
      hist.delete();
      m_fill = 0; m_tapsq = 0; m_out = '0; m_vld = 1'b0; m_known = 1'b1;
    end else if (en) begin
      chg = 1'b0;
`ifdef DELAY_LINE_TAP_FLUSH_EN
      chg = (taps != m_tapsq);
      m_tapsq = taps;
`endif
      m_vld = (m_fill >= taps) && !chg;
      if (taps == 0) begin
        m_out = data; m_known = 1'b1;
      end else if (hist.size() >= taps) begin
        m_out = hist[hist.size() - taps]; m_known = 1'b1;
      end else begin
        m_known = 1'b0;  // stale RAM contents, not predictable
      end
      hist.push_back(data);
      if (hist.size() > MAXD + 1) void'(hist.pop_front());
      if (chg) m_fill = 1;
      else if (m_fill < MAXD) m_fill = m_fill + 1;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [DB-1:0] taps, input logic [DW-1:0] data);
    i_rst = rst; i_shift_en = en; i_shift_taps = taps; i_data_in = data;
    @(posedge i_clk); #1;
    model_step(rst, en, int'(taps), data);
    chk("model_vld", {31'd0, o_data_valid}, {31'd0, m_vld});
    if (m_known) chk("model_out", {16'd0, o_data_out}, {16'd0, m_out});
  endtask

  typedef struct {
    bit            rst;
    bit            en;
    logic [DB-1:0] taps;
    logic [DW-1:0] data;
    logic [DW-1:0] eout;
    bit            evld;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 1'b1, 4'd0, 16'hFFFF, 16'h0000, 1'b0}; // reset beats enable
    vt[1] = '{1'b0, 1'b1, 4'd0, 16'hA5A5, 16'hA5A5, 1'b1}; // pass-through first enable
    vt[2] = '{1'b0, 1'b0, 4'd0, 16'h5555, 16'hA5A5, 1'b0}; // hold
    vt[3] = '{1'b0, 1'b1, 4'd0, 16'h1234, 16'h1234, 1'b1};
    vt[4] = '{1'b0, 1'b1, 4'd1, 16'h4321, 16'h1234, 1'b1}; // taps=1 after 2 samples
    vt[5] = '{1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0}; // reset clears outputs

    i_rst = 1'b1; i_shift_en = 1'b0; i_shift_taps = '0; i_data_in = '0;
    @(posedge i_clk); #1;
    model_step(1'b1, 1'b0, 0, '0);
    chk("reset_out", {16'd0, o_data_out}, 32'd0);
    chk("reset_vld", {31'd0, o_data_valid}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      cyc(vt[i].rst, vt[i].en, vt[i].taps, vt[i].data);
      chk($sformatf("vec%0d_out", i), {16'd0, o_data_out}, {16'd0, vt[i].eout});
      chk($sformatf("vec%0d_vld", i), {31'd0, o_data_valid}, {31'd0, vt[i].evld});
    end

    // Ramp with taps=3: first valid after 4th enable, output 1
    cyc(1'b1, 1'b0, 4'd3, '0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b1, 4'd3, 16'(i));
      if (i == 3) chk("ramp_vld3", {31'd0, o_data_valid}, 32'd0);
      if (i == 4) begin
        chk("ramp_first_vld", {31'd0, o_data_valid}, 32'd1);
        chk("ramp_first_out", {16'd0, o_data_out}, 32'd1);
      end
    end

    // Gapped enables with wrap, taps=15, samples 0..39
    cyc(1'b1, 1'b0, 4'd15, '0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b1, 4'd15, 16'(k));
      if (k == 20) chk("gap_out20", {16'd0, o_data_out}, 32'd5);
      cyc(1'b0, 1'b0, 4'd15, 16'hDEAD);
      if (k == 20) begin
        chk("gap_hold_out", {16'd0, o_data_out}, 32'd5);
        chk("gap_hold_vld", {31'd0, o_data_valid}, 32'd0);
      end
    end

    // Tap change 2 -> 5 at sample 20
    cyc(1'b1, 1'b0, 4'd2, '0);
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b1, (k < 20) ? 4'd2 : 4'd5, 16'(k));
`ifdef DELAY_LINE_TAP_FLUSH_EN
      if (k == 20) chk("tapchg_vld_drop", {31'd0, o_data_valid}, 32'd0);
      if (k == 25) begin
        chk("tapchg_revld", {31'd0, o_data_valid}, 32'd1);
        chk("tapchg_out25", {16'd0, o_data_out}, 32'd20);
      end
`else
      if (k == 20) begin
        chk("tapchg_vld", {31'd0, o_data_valid}, 32'd1);
        chk("tapchg_jump", {16'd0, o_data_out}, 32'd15);
      end
`endif
    end

    // Reset mid-operation with enable high
    cyc(1'b1, 1'b0, 4'd2, '0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 4'd2, 16'(k));
    cyc(1'b1, 1'b1, 4'd2, 16'd10);
    chk("midrst_out", {16'd0, o_data_out}, 32'd0);
    chk("midrst_vld", {31'd0, o_data_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 4'd2, 16'(200 + k));
      if (k < 2) chk("midrst_novld", {31'd0, o_data_valid}, 32'd0);
      else begin
        chk("midrst_vld3", {31'd0, o_data_valid}, 32'd1);
        chk("midrst_out3", {16'd0, o_data_out}, 32'd200);
      end
    end

    // Maximum delay
    cyc(1'b1, 1'b0, 4'd15, '0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 4'd15, 16'(100 + k));
      if (k == 14) chk("maxd_15th_vld", {31'd0, o_data_valid}, 32'd0);
      if (k == 15) begin
        chk("maxd_16th_vld", {31'd0, o_data_valid}, 32'd1);
        chk("maxd_16th_out", {16'd0, o_data_out}, 32'd100);
      end
    end

    // Randomized stream against the model
    begin
      logic [DB-1:0] taps;
      taps = 4'd7;
      cyc(1'b1, 1'b0, taps, '0);
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(49) == 0) taps = DB'($urandom_range(MAXD));
        cyc(($urandom_range(199) == 0), ($urandom_range(9) < 7), taps, DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_line_reader.md
Name: delay_line_reader

Overview:
- Read-side counterpart to the team's tapped shift-register delay line.
- Holds samples in a circular RAM of 2**DEEP_BIT entries and returns, on each enabled cycle, the sample accepted a programmable number of enables earlier.
- Adds fill tracking so downstream logic (complex-multiplier operand alignment) knows when the delayed output is genuine rather than stale memory.

Parameters:
- DEEP_BIT, 4, address width; buffer depth = 2**DEEP_BIT; maximum delay = 2**DEEP_BIT-1.
- DATA_WIDTH, 16, sample width in bits.

Ports:
- i_clk  input  1  sole clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_shift_en  input  1  sample strobe; one sample accepted per high cycle.
- i_shift_taps  input  DEEP_BIT  delay in enabled samples, 0..2**DEEP_BIT-1.
- i_data_in  input  DATA_WIDTH  sample accepted when i_shift_en=1.
- o_data_out  output  DATA_WIDTH  delayed sample, registered.
- o_data_valid  output  1  one-cycle pulse: o_data_out holds a genuinely delayed sample.

Behaviour:
- Reset values. i_rst=1 at a clock edge forces the following to 0: wr_ptr, fill_cnt, o_data_out and o_data_valid. RAM contents are not reset. Reset has priority over i_shift_en in the same cycle.
- Write. On an edge with i_shift_en=1: mem[wr_ptr] <= i_data_in, and wr_ptr increments modulo 2**DEEP_BIT (wraps 2**DEEP_BIT-1 -> 0).
- Read address. rd_addr = (wr_ptr - i_shift_taps) mod 2**DEEP_BIT, using the current wr_ptr before its increment.
- Output, same edge as the write:
  - taps=0: o_data_out <= i_data_in (bypass; no read-during-write dependency).
  - taps>0: o_data_out <= mem[rd_addr].
- Latency. o_data_out changes exactly 1 clock after the enabled cycle. The value equals the sample accepted i_shift_taps enables before the current one.
- Hold. With i_shift_en=0, o_data_out holds its value, o_data_valid=0, and no pointer moves.
- Fill counter. fill_cnt counts accepted samples and saturates at 2**DEEP_BIT-1. It increments on each enabled cycle, after the valid comparison.
- Valid. o_data_valid <= i_shift_en && (fill_cnt >= i_shift_taps), using the pre-increment fill_cnt.
  - taps=0: valid on every enabled cycle, including the first after reset.
  - taps=N: first valid on enable number N+1 after reset.
- Tap change. i_shift_taps is sampled combinationally every enabled cycle. A new value takes effect on the next enabled edge. There is no flush; validity is re-judged against the retained fill_cnt.
- Wrap. Pointer arithmetic is DEEP_BIT-bit unsigned with natural wrap; no special case at address 0.
- Simultaneous events. Write and read of the same address cannot occur for taps>0, since rd_addr != wr_ptr.

Optional Feature:
- Macro: DELAY_LINE_TAP_FLUSH_EN.
- Defined:
  - A registered copy of the taps, taps_q, updates on enabled cycles.
  - If an enabled cycle sees i_shift_taps != taps_q, fill_cnt restarts at 1 (the current sample) and o_data_valid is forced 0 for that cycle.
  - Valid therefore reasserts only after i_shift_taps further enables, so no sample mixing old and new alignment is flagged valid.
  - taps_q resets to 0.
- Undefined: no taps_q register; tap changes are applied silently as described in Behaviour.

Decomposition:
- Shared package: the depth constant derived from DEEP_BIT and the maximum-delay constant 2**DEEP_BIT-1. The complex-multiplier top also uses both to size its alignment.
- Sub-module: sdp_ram, a simple dual-port RAM with one write port and one asynchronous-read port. Parameters are DEEP_BIT and DATA_WIDTH. No reset; it maps to distributed RAM.
- delay_line_reader holds the pointers, fill counter, bypass mux and valid logic.

Test Plan:
- Reset then ramp. taps=3; enable every cycle with data 1,2,3,…. Valid first pulses 1 clk after the 4th enable, with o_data_out=1. Output then tracks input-3 each cycle.
- Pass-through. taps=0, data 0xA5A5 on the first enable after reset. Next clk: o_data_out=0xA5A5, o_data_valid=1.
- Gapped enable and wrap. DEEP_BIT=4, taps=15, enable on alternate cycles for 40 samples 0..39. Outputs are sample k-15 for k>=15. No glitch at the pointer wrap after 16 samples. Valid stays 0 on idle cycles, and o_data_out holds.
- Tap change mid-stream. taps 2->5 at sample 20, fill_cnt already at 15.
  - Macro undefined: valid stays asserted and the output jumps to sample 15.
  - Macro defined: valid drops for 5 enables; the first valid output is sample 20 after 5 more samples.
- Reset mid-operation. Assert i_rst for 1 cycle at sample 10 together with i_shift_en=1. The sample is not written, outputs are 0, and fill restarts: with taps=2, the next valid comes on the 3rd enable after reset.
- Maximum delay. taps=15 after exactly 15 enables: valid is 0. On the 16th enable valid=1 and o_data_out=first sample.
